// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the external-RAM bus controller: RAM control pin
// positions and controller state encodings.
package mem_bus_ctrl_pkg;

  localparam int unsigned RAM_READ_PIN  = 0;
  localparam int unsigned RAM_WRITE_PIN = 1;
  localparam int unsigned RAM_ACK_PIN   = 0;

  typedef enum logic [1:0] {
    MB_IDLE   = 2'd0,
    MB_ACCESS = 2'd1,
    MB_DONE   = 2'd2
  } mb_state_t;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after
// the pointer, wrapping at NCH. The pointer register is owned by the caller.
module rr_arbiter
  import mem_bus_ctrl_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned PW  = ptr_width(NCH)
) (
  input  logic [NCH-1:0] i_req,
  input  logic [PW-1:0]  i_ptr,
  output logic [NCH-1:0] o_grant,
  output logic [PW-1:0]  o_idx,
  output logic           o_any
);

  always_comb begin
    int unsigned c;
    logic        found;
    o_grant = '0;
    o_idx   = '0;
    found   = 1'b0;
    c       = 0;
    for (int unsigned k = 0; k < NCH; k++) begin
      c = (int'(i_ptr) + k) % NCH;
      if (!found && i_req[c]) begin
        found      = 1'b1;
        o_grant[c] = 1'b1;
        o_idx      = c[PW-1:0];
      end
    end
    o_any = found;
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Multi-channel external-RAM bus controller: round-robin grant, one registered
// read/write transaction at a time, ack wait with timeout, per-channel response.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int unsigned NCH     = 4,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned CTRL_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    req_valid,
  input  logic [NCH-1:0]    req_we,
  input  logic [NCH*AW-1:0] req_addr,
  input  logic [NCH*DW-1:0] req_wdata,
  output logic [NCH-1:0]    req_ready,
  output logic [NCH-1:0]    rsp_valid,
  output logic              rsp_err,
  output logic [DW-1:0]     rsp_rdata,
  output logic [CTRL_W-1:0] ram_ctrl_to_hw,
  input  logic [CTRL_W-1:0] ram_ctrl_from_hw,
  output logic [AW-1:0]     addr,
  output logic [DW-1:0]     data_to_hw,
  input  logic [DW-1:0]     data_from_hw
);

  localparam int unsigned PW   = ptr_width(NCH);
  localparam logic [7:0]  TO_C = 8'(TIMEOUT);

  mb_state_t         r_state, w_state_nxt;
  logic [PW-1:0]     r_ptr, w_ptr_nxt;
  logic [PW-1:0]     r_gidx, w_gidx_nxt;
  logic              r_we, w_we_nxt;
  logic [AW-1:0]     r_addr, w_addr_nxt;
  logic [DW-1:0]     r_wdata, w_wdata_nxt;
  logic [7:0]        r_cnt, w_cnt_nxt;

  logic [NCH-1:0]    r_req_ready, w_req_ready_nxt;
  logic [NCH-1:0]    r_rsp_valid, w_rsp_valid_nxt;
  logic              r_rsp_err, w_rsp_err_nxt;
  logic [DW-1:0]     r_rsp_rdata, w_rsp_rdata_nxt;
  logic [CTRL_W-1:0] r_ctrl, w_ctrl_nxt;
  logic [AW-1:0]     r_addr_o, w_addr_o_nxt;
  logic [DW-1:0]     r_data_o, w_data_o_nxt;

  logic [NCH-1:0]    w_grant;
  logic [PW-1:0]     w_idx;
  logic              w_any;
  logic              w_ack;
  logic [CTRL_W-1:0] w_cmd_ctrl;
  logic              w_unused_ctrl;

  rr_arbiter #(.NCH(NCH), .PW(PW)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_ack         = ram_ctrl_from_hw[RAM_ACK_PIN];
  assign w_unused_ctrl = ^ram_ctrl_from_hw;

  always_comb begin
    w_cmd_ctrl                = '0;
    w_cmd_ctrl[RAM_READ_PIN]  = ~r_we;
    w_cmd_ctrl[RAM_WRITE_PIN] = r_we;
  end

  // ACCESS with r_cnt == 0 is the req_ready cycle: pins are being set up and
  // ack is not yet meaningful. r_cnt == k means pins have been up for k cycles.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_gidx_nxt      = r_gidx;
    w_we_nxt        = r_we;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_cnt_nxt       = r_cnt;
    w_req_ready_nxt = '0;
    w_rsp_valid_nxt = '0;
    w_rsp_err_nxt   = 1'b0;
    w_rsp_rdata_nxt = '0;
    w_ctrl_nxt      = '0;
    w_addr_o_nxt    = '0;
    w_data_o_nxt    = '0;
    unique case (r_state)
      MB_IDLE: begin
        if (w_any) begin
          w_req_ready_nxt = w_grant;
          w_gidx_nxt      = w_idx;
          w_we_nxt        = req_we[w_idx];
          w_addr_nxt      = req_addr[w_idx*AW +: AW];
          w_wdata_nxt     = req_wdata[w_idx*DW +: DW];
          w_ptr_nxt       = (w_idx == PW'(NCH-1)) ? '0 : w_idx + 1'b1;
          w_cnt_nxt       = '0;
          w_state_nxt     = MB_ACCESS;
        end
      end
      MB_ACCESS: begin
        if (r_cnt != '0 && (w_ack || r_cnt == TO_C)) begin
          w_state_nxt               = MB_DONE;
          w_rsp_valid_nxt[r_gidx]   = 1'b1;
          w_rsp_err_nxt             = ~w_ack;
          w_rsp_rdata_nxt           = (w_ack && !r_we) ? data_from_hw : '0;
          w_cnt_nxt                 = '0;
        end else begin
          w_ctrl_nxt   = w_cmd_ctrl;
          w_addr_o_nxt = r_addr;
          w_data_o_nxt = r_we ? r_wdata : '0;
          w_cnt_nxt    = r_cnt + 8'd1;
        end
      end
      MB_DONE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = MB_IDLE;
      end
      default: w_state_nxt = MB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= MB_IDLE;
      r_ptr       <= '0;
      r_gidx      <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_ctrl      <= '0;
      r_addr_o    <= '0;
      r_data_o    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_gidx      <= w_gidx_nxt;
      r_we        <= w_we_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_cnt       <= w_cnt_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_ctrl      <= w_ctrl_nxt;
      r_addr_o    <= w_addr_o_nxt;
      r_data_o    <= w_data_o_nxt;
    end
  end

  assign req_ready      = r_req_ready;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_err        = r_rsp_err;
  assign rsp_rdata      = r_rsp_rdata;
  assign ram_ctrl_to_hw = r_ctrl;
  assign addr           = r_addr_o;
  assign data_to_hw     = r_data_o;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed self-checking bench for mem_bus_ctrl: reset, reads, writes,
// timeout, ack/timeout tie, mid-access reset and round-robin ordering.
module tb_mem_bus_ctrl;
  import mem_bus_ctrl_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid, req_we, req_ready, rsp_valid;
  logic [127:0] req_addr, req_wdata;
  logic         rsp_err;
  logic [31:0]  rsp_rdata, ram_ctrl_to_hw, ram_ctrl_from_hw, addr, data_to_hw, data_from_hw;

  int n_checks = 0;
  int n_fail   = 0;

  mem_bus_ctrl #(
    .NCH(4), .AW(32), .DW(32), .CTRL_W(32), .TIMEOUT(15)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_we           (req_we),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .req_ready        (req_ready),
    .rsp_valid        (rsp_valid),
    .rsp_err          (rsp_err),
    .rsp_rdata        (rsp_rdata),
    .ram_ctrl_to_hw   (ram_ctrl_to_hw),
    .ram_ctrl_from_hw (ram_ctrl_from_hw),
    .addr             (addr),
    .data_to_hw       (data_to_hw),
    .data_from_hw     (data_from_hw)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pins_up();
    return ram_ctrl_to_hw[RAM_READ_PIN] | ram_ctrl_to_hw[RAM_WRITE_PIN];
  endfunction

  // Single transaction on one channel; ack_cyc = pin cycle on which ack is
  // raised (0 = never, forcing a timeout).
  task automatic do_txn(input string nm, input int ch, input logic we,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int ack_cyc, input logic [31:0] rd);
    int cyc = 0, rdy_at = -1, first_pin = -1, rsp_at = -1;
    int pins = 0, wrong = 0, bad = 0, exp_pins;
    logic [3:0]  rdy_v = '0, rsp_v = '0;
    logic        err_v = 1'b0, exp_err;
    logic [31:0] rdata_v = '0;
    exp_err  = !(ack_cyc >= 1 && ack_cyc <= 15);
    exp_pins = exp_err ? 15 : ack_cyc;
    req_valid[ch]          = 1'b1;
    req_we[ch]             = we;
    req_addr[ch*32 +: 32]  = a;
    req_wdata[ch*32 +: 32] = wd;
    while (rsp_at < 0 && cyc < 40) begin
      step();
      cyc++;
      if (req_ready != '0) begin
        rdy_v = req_ready;
        rdy_at = cyc;
        req_valid[ch] = 1'b0;
      end
      ram_ctrl_from_hw = '0;
      data_from_hw     = 32'hFFFF_0000;
      if ((ram_ctrl_to_hw & ~32'h3) != '0) wrong++;
      if (pins_up()) begin
        pins++;
        if (first_pin < 0) first_pin = cyc;
        if (ram_ctrl_to_hw[we ? RAM_READ_PIN : RAM_WRITE_PIN]) wrong++;
        if (addr !== a || data_to_hw !== (we ? wd : 32'h0)) bad++;
        if (pins == ack_cyc) begin
          ram_ctrl_from_hw[RAM_ACK_PIN] = 1'b1;
          data_from_hw = rd;
        end
      end
      if (rsp_valid != '0) begin
        rsp_v = rsp_valid;
        rsp_at = cyc;
        err_v = rsp_err;
        rdata_v = rsp_rdata;
      end
    end
    ram_ctrl_from_hw = '0;
    check({nm, "_ready"},     64'(rdy_v), 64'(4'b1 << ch));
    check({nm, "_pins"},      64'(pins), 64'(exp_pins));
    check({nm, "_pin_start"}, 64'(first_pin), 64'(rdy_at + 1));
    check({nm, "_rsp"},       64'(rsp_v), 64'(4'b1 << ch));
    check({nm, "_rsp_lat"},   64'(rsp_at), 64'(rdy_at + exp_pins + 1));
    check({nm, "_err"},       64'(err_v), 64'(exp_err));
    if (!we) check({nm, "_rdata"}, 64'(rdata_v), exp_err ? 64'h0 : 64'(rd));
    check({nm, "_wrong_pin"}, 64'(wrong), 64'h0);
    check({nm, "_bus"},       64'(bad), 64'h0);
    step();
    check({nm, "_rsp_pulse"}, 64'({rsp_valid, pins_up()}), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int grants, rsps, n;
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    ram_ctrl_from_hw = '0; data_from_hw = '0;
    step(); step();
    check("rst_ctrl", 64'(ram_ctrl_to_hw), 64'h0);
    check("rst_hs",   64'({req_ready, rsp_valid, rsp_err}), 64'h0);
    check("rst_addr", 64'(addr), 64'h0);
    check("rst_data", 64'({data_to_hw, rsp_rdata}), 64'h0);
    rst = 1'b0;
    step();

    // ack while idle must not start anything
    ram_ctrl_from_hw[RAM_ACK_PIN] = 1'b1;
    step(); step(); step();
    check("idle_ack", 64'({rsp_valid, req_ready, ram_ctrl_to_hw}), 64'h0);
    ram_ctrl_from_hw = '0;
    step();

    do_txn("rd0",  0, 1'b0, 32'h0000_0100, 32'h0,           2,  32'hDEAD_BEEF);
    do_txn("wr2",  2, 1'b1, 32'h0000_0040, 32'h1234_5678,   1,  32'h0);
    do_txn("tmo1", 1, 1'b0, 32'h0000_0200, 32'h0,           0,  32'hCAFE_F00D);
    do_txn("tie3", 3, 1'b0, 32'h0000_0300, 32'h0,           15, 32'hA5A5_5A5A);

    // reset in the middle of a ch1 read: ptr would be 2 afterwards otherwise
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[32 +: 32] = 32'h0000_0500;
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      step();
      if (req_ready != '0) req_valid[1] = 1'b0;
      if (pins_up()) n++;
    end
    check("mid_pins_seen", 64'(n), 64'd3);
    rst = 1'b1;
    req_valid = '0;
    step();
    check("mid_rst_ctrl", 64'(ram_ctrl_to_hw), 64'h0);
    check("mid_rst_hs",   64'({req_ready, rsp_valid, rsp_err}), 64'h0);
    check("mid_rst_bus",  64'({addr, data_to_hw}), 64'h0);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (rsp_valid != '0 || pins_up()) n++;
    end
    check("mid_no_rsp", 64'(n), 64'h0);

    // all four channels request continuously
    for (int c = 0; c < 4; c++) begin
      req_we[c] = 1'b0;
      req_addr[c*32 +: 32] = 32'h0000_1000 + 32'(c) * 32'h10;
    end
    req_valid = 4'hF;
    grants = 0; rsps = 0;
    for (int i = 0; i < 200 && rsps < 8; i++) begin
      step();
      ram_ctrl_from_hw = '0;
      data_from_hw = 32'h0;
      if (req_ready != '0) begin
        check("rr_grant", 64'(req_ready), 64'(4'b1 << (grants % 4)));
        grants++;
        if (grants == 8) req_valid = '0;
      end
      if (ram_ctrl_to_hw[RAM_READ_PIN]) begin
        ram_ctrl_from_hw[RAM_ACK_PIN] = 1'b1;
        data_from_hw = addr ^ 32'h5555_0000;
      end
      if (rsp_valid != '0) begin
        check("rr_rsp", 64'(rsp_valid), 64'(4'b1 << (rsps % 4)));
        check("rr_rdata", 64'(rsp_rdata),
              64'((32'h0000_1000 + 32'(rsps % 4) * 32'h10) ^ 32'h5555_0000));
        rsps++;
      end
    end
    ram_ctrl_from_hw = '0;
    check("rr_grants", 64'(grants), 64'd8);
    check("rr_rsps",   64'(rsps), 64'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
